// File: rtl/l8_pkg.sv
// Shared definitions for the high-memory subordinate: address map, bus types and
// the access FSM state encoding.
package l8_pkg;

    // Address map
    localparam logic [15:0] HMEM_RAM_BASE = 16'h0100;
    localparam logic [15:0] HMEM_IO_BASE  = 16'hFF00;

    // Timer register offsets within the IO page
    localparam logic [1:0] REG_TCTL = 2'd0;
    localparam logic [1:0] REG_TCNT = 2'd1;
    localparam logic [1:0] REG_TRLD = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } hmem_state_t;

    // Target of a latched access
    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_REG,
        RGN_NONE
    } hmem_rgn_t;

    // Core data-bus request as seen by a subordinate
    typedef struct packed {
        logic [15:0] addr;
        logic        rreq;
        logic        wreq;
        logic [7:0]  wdata;
    } bus_t;

    // Core instruction word
    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] operand;
    } inst_t;

    // Everything outside the zero page belongs to this subordinate
    function automatic logic is_hmem(input logic [15:0] a);
        return a[15:8] != 8'h00;
    endfunction

    // The four timer registers at the bottom of the IO page
    function automatic logic is_reg(input logic [15:0] a);
        return a[15:2] == HMEM_IO_BASE[15:2];
    endfunction

endpackage

// File: rtl/hmem_timer.sv
// Interval timer: prescaler, down-counter with reload, pending flag and IRQ.
module hmem_timer
    import l8_pkg::*;
#(
    parameter logic [7:0] PRESC = 8'd100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reg_we,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_wdata,
    output logic [7:0] reg_rdata,
    output logic       irq
);

    logic [7:0] presc_q;
    logic [7:0] tcnt_q;
    logic [7:0] trld_q;
    logic       en_q;
    logic       ie_q;
    logic       pend_q;

    logic tick;
    logic reload;
    logic wr_tctl;
    logic wr_tcnt;
    logic wr_trld;
    logic wr_stat;

    assign tick    = en_q && (presc_q == PRESC - 8'd1);
    assign reload  = tick && (tcnt_q == '0);
    assign wr_tctl = reg_we && (reg_addr == REG_TCTL);
    assign wr_tcnt = reg_we && (reg_addr == REG_TCNT);
    assign wr_trld = reg_we && (reg_addr == REG_TRLD);
    assign wr_stat = reg_we && (reg_addr == REG_STAT);

    // Prescaler: free-runs 0..PRESC-1 while enabled, held at zero otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else if (!en_q || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 8'd1;
        end
    end

    // Control and reload registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q   <= 1'b0;
            ie_q   <= 1'b0;
            trld_q <= '0;
        end else begin
            if (wr_tctl) begin
                en_q <= reg_wdata[0];
                ie_q <= reg_wdata[1];
            end
            if (wr_trld) begin
                trld_q <= reg_wdata;
            end
        end
    end

    // Counter: a bus write overrides whatever the tick would have done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt_q <= '0;
        end else if (wr_tcnt) begin
            tcnt_q <= reg_wdata;
        end else if (reload) begin
            tcnt_q <= trld_q;
        end else if (tick) begin
            tcnt_q <= tcnt_q - 8'd1;
        end
    end

    // Pending flag: write-1-to-clear, a coincident reload wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= (pend_q && !(wr_stat && reg_wdata[0])) || reload;
        end
    end

    // Register read mux, side-effect free
    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            REG_TCTL: reg_rdata = {6'b0, ie_q, en_q};
            REG_TCNT: reg_rdata = tcnt_q;
            REG_TRLD: reg_rdata = trld_q;
            REG_STAT: reg_rdata = {7'b0, pend_q};
            default:  reg_rdata = '0;
        endcase
    end

    assign irq = pend_q && ie_q;

endmodule

// File: rtl/hmem_ctrl.sv
// High-memory bus subordinate: address decode, wait-state FSM, byte RAM and the
// interval timer. Each accepted request gets exactly one single-cycle ack.
module hmem_ctrl
    import l8_pkg::*;
#(
    parameter logic [15:0] RAM_BYTES = 16'h0F00,
    parameter int unsigned WAIT_RAM  = 1,
    parameter int unsigned WAIT_IO   = 0,
    parameter logic [7:0]  PRESC     = 8'd100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        rreq,
    input  logic        wreq,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ack,
    output logic        irq
);

    localparam int unsigned RAM_DEPTH = int'(RAM_BYTES);
    localparam int unsigned AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [3:0]  WC_RAM    = 4'(WAIT_RAM);
    localparam logic [3:0]  WC_IO     = 4'(WAIT_IO);

    bus_t        bus;
    logic        req;
    hmem_rgn_t   rgn_live;

    hmem_state_t state_q;
    hmem_state_t state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        capture;
    logic        commit;

    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        wr_q;
    hmem_rgn_t   rgn_q;

    logic [AW-1:0] ram_idx;
    logic [7:0]    mem [RAM_DEPTH];

    logic       tmr_we;
    logic [7:0] tmr_rdata;

    assign bus = '{addr: addr, rreq: rreq, wreq: wreq, wdata: wdata};
    assign req = bus.rreq || bus.wreq;

    // Decode the live address; only meaningful when it is a high-memory access
    always_comb begin
        rgn_live = RGN_NONE;
        if (({1'b0, bus.addr} >= {1'b0, HMEM_RAM_BASE}) &&
            ({1'b0, bus.addr} <  ({1'b0, HMEM_RAM_BASE} + {1'b0, RAM_BYTES}))) begin
            rgn_live = RGN_RAM;
        end else if (is_reg(bus.addr)) begin
            rgn_live = RGN_REG;
        end
    end

    // Access FSM next state; commit marks the edge that enters ACK
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && is_hmem(bus.addr)) begin
                    state_d = ST_WAIT;
                    capture = 1'b1;
                    cnt_d   = (rgn_live == RGN_RAM) ? WC_RAM : WC_IO;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch the access on leaving IDLE; both strobes together count as a write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rgn_q   <= RGN_NONE;
        end else if (capture) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            wr_q    <= bus.wreq;
            rgn_q   <= rgn_live;
        end
    end

    assign ram_idx = AW'(addr_q - HMEM_RAM_BASE);

    // RAM array, synchronous write at the commit edge
    always_ff @(posedge clk) begin
        if (commit && wr_q && (rgn_q == RGN_RAM)) begin
            mem[ram_idx] <= wdata_q;
        end
    end

    // Read data registered at the commit edge and held until the next read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (commit && !wr_q) begin
            case (rgn_q)
                RGN_RAM: rdata <= mem[ram_idx];
                RGN_REG: rdata <= tmr_rdata;
                default: rdata <= 8'hFF;
            endcase
        end
    end

    assign tmr_we = commit && wr_q && (rgn_q == RGN_REG);
    assign ack    = (state_q == ST_ACK);

    hmem_timer #(
        .PRESC (PRESC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .reg_we    (tmr_we),
        .reg_addr  (addr_q[1:0]),
        .reg_wdata (wdata_q),
        .reg_rdata (tmr_rdata),
        .irq       (irq)
    );

endmodule

// File: tb/tb_hmem_ctrl.sv
// Self-checking bench for hmem_ctrl: bus transfers against a scoreboard of
// expected acks/read data, plus cycle-exact timer checks.
module tb_hmem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addr = '0;
    logic        rreq = 1'b0;
    logic        wreq = 1'b0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        ack;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ack_cnt = 0;
    int n_xfer  = 0;
    int last_ack_cyc = 0;

    typedef struct {
        bit         rd;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    hmem_ctrl #(
        .RAM_BYTES (16'h0F00),
        .WAIT_RAM  (1),
        .WAIT_IO   (0),
        .PRESC     (8'd2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .rreq  (rreq),
        .wreq  (wreq),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Ack monitor: every ack must match the oldest outstanding transfer
    always @(negedge clk) begin
        if (rst && ack) begin
            exp_t e;
            ack_cnt++;
            last_ack_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                if (e.rd) check("rdata", rdata, e.data);
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; drives one transfer, checks latency, returns at posedge+1
    // after the ack cycle with the request released.
    task automatic xfer(input bit wr, input logic [15:0] a, input logic [7:0] d, input int lat);
        int  s;
        bit  got;
        exp_q.push_back('{rd: !wr, data: d});
        s     = cyc;
        addr  = a;
        wdata = d;
        wreq  = wr;
        rreq  = !wr;
        got   = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            n_xfer++;
            check($sformatf("lat_%h", a), cyc - s, lat);
        end else begin
            check($sformatf("ack_timeout_%h", a), 32'd0, 32'd1);
        end
        next_cycle();
        rreq = 1'b0;
        wreq = 1'b0;
    endtask

    task automatic wait_irq(output int at);
        at = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (irq) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("irq_timeout", 32'd0, 32'd1);
    endtask

    task automatic goto_cycle(input int t);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            next_cycle();
            if (cyc == t) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("sync_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, t_en, r0, r1, rl;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_irq", irq, 1'b0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        // RAM write/readback, WAIT_RAM=1 -> ack in cycle 3
        xfer(1'b1, 16'h0100, 8'h5A, 3);
        xfer(1'b0, 16'h0100, 8'h5A, 3);

        // Back-to-back writes, no idle gap
        xfer(1'b1, 16'h0100, 8'h11, 3);
        xfer(1'b1, 16'h0101, 8'h22, 3);
        xfer(1'b0, 16'h0100, 8'h11, 3);
        xfer(1'b0, 16'h0101, 8'h22, 3);

        // RAM upper boundary and first unmapped byte past it
        xfer(1'b1, 16'h0FFF, 8'hA5, 3);
        xfer(1'b0, 16'h0FFF, 8'hA5, 3);
        xfer(1'b0, 16'h1000, 8'hFF, 2);

        // Unmapped IO: reads FF, writes dropped but acked
        xfer(1'b0, 16'hFF20, 8'hFF, 2);
        xfer(1'b1, 16'hFF20, 8'h03, 2);
        xfer(1'b0, 16'hFF00, 8'h00, 2);
        xfer(1'b0, 16'hFF02, 8'h00, 2);

        // Zero-page request is never acked
        a0   = ack_cnt;
        addr = 16'h0050;
        rreq = 1'b1;
        repeat (8) @(negedge clk);
        check("lowaddr_noack", ack_cnt - a0, 0);
        next_cycle();
        rreq = 1'b0;
        next_cycle();

        // Abort: drop rreq while WAIT still has a cycle to go
        a0   = ack_cnt;
        addr = 16'h0100;
        rreq = 1'b1;
        next_cycle();
        rreq = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_noack", ack_cnt - a0, 0);
        next_cycle();
        xfer(1'b0, 16'h0100, 8'h11, 3);

        // Reset during WAIT of a write: no ack, byte unchanged
        addr  = 16'h0101;
        wdata = 8'hEE;
        wreq  = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ack", ack, 1'b0);
        check("rst_mid_rdata", rdata, 8'h00);
        next_cycle();
        wreq = 1'b0;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_post_ack", ack, 1'b0);
        next_cycle();
        xfer(1'b0, 16'h0101, 8'h22, 3);

        // Timer: PRESC=2, TRLD=3, TCNT=0, enable with ie
        xfer(1'b1, 16'hFF02, 8'h03, 2);
        xfer(1'b1, 16'hFF01, 8'h00, 2);
        xfer(1'b1, 16'hFF00, 8'h03, 2);
        t_en = last_ack_cyc;
        wait_irq(r0);
        check("first_reload", r0 - t_en, 2);

        // Clear pend well away from any reload
        next_cycle();
        xfer(1'b1, 16'hFF03, 8'h01, 2);
        @(negedge clk);
        check("irq_cleared", irq, 1'b0);
        wait_irq(r1);
        check("reload_gap", r1 - r0, 8);

        // W1C lands exactly on the next reload edge: pend must survive
        rl = r1 + 8;
        goto_cycle(rl - 2);
        xfer(1'b1, 16'hFF03, 8'h01, 2);
        @(negedge clk);
        check("clr_vs_tick", irq, 1'b1);

        // TCNT write on a tick edge (rl+4), then one more tick before the read samples
        goto_cycle(rl + 2);
        xfer(1'b1, 16'hFF01, 8'h40, 2);
        xfer(1'b0, 16'hFF01, 8'h3F, 2);

        // STAT read has no side effects; disabling keeps pend
        xfer(1'b0, 16'hFF03, 8'h01, 2);
        @(negedge clk);
        check("stat_read_keeps", irq, 1'b1);
        next_cycle();
        xfer(1'b1, 16'hFF00, 8'h02, 2);
        @(negedge clk);
        check("en_off_irq", irq, 1'b1);
        next_cycle();
        xfer(1'b0, 16'hFF00, 8'h02, 2);
        xfer(1'b0, 16'hFF03, 8'h01, 2);

        repeat (4) @(negedge clk);
        check("ack_total", ack_cnt, n_xfer);
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
